// File: rtl/convert_w_w_if.sv
// Stream bundle for convert_w_w: input-side and output-side ready/valid signals.
// CONVERT_W_W_LAST_EN adds the i_last/o_last frame marker.
interface convert_w_w_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 32
) ();
    logic [IN_W-1:0]  i_data;
    logic             i_rval;
    logic             o_rrdy;
    logic [OUT_W-1:0] o_data;
    logic             o_tval;
    logic             i_trdy;
`ifdef CONVERT_W_W_LAST_EN
    logic             i_last;
    logic             o_last;

    modport slave  (input  i_data, i_rval, i_trdy, i_last, output o_rrdy, o_data, o_tval, o_last);
    modport master (output i_data, i_rval, i_trdy, i_last, input  o_rrdy, o_data, o_tval, o_last);
`else
    modport slave  (input  i_data, i_rval, i_trdy, output o_rrdy, o_data, o_tval);
    modport master (output i_data, i_rval, i_trdy, input  o_rrdy, o_data, o_tval);
`endif
endinterface

// File: rtl/convert_w_w.sv
// Ready/valid stream width converter: upsize packs, downsize splits, equal width pipelines.
// Optional CONVERT_W_W_LAST_EN adds frame-end marking with early flush on upsize.
module convert_w_w #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    convert_w_w_if.slave  bus
);
    localparam int unsigned MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int unsigned MIN_W = (IN_W > OUT_W) ? OUT_W : IN_W;
    localparam int unsigned RATIO = MAX_W / MIN_W;
    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic rrdy_c;
    logic i_xfer_c;
    logic o_xfer_c;
    logic last_in_c;

    assign bus.o_rrdy = rrdy_c;
    assign i_xfer_c   = bus.i_rval & rrdy_c;
    assign o_xfer_c   = bus.o_tval & bus.i_trdy;
`ifdef CONVERT_W_W_LAST_EN
    assign last_in_c  = bus.i_last;
`else
    assign last_in_c  = 1'b0;
`endif

    if ((MAX_W % MIN_W) != 0) begin : g_illegal
        $error("convert_w_w: wider width must be an exact multiple of narrower width");
    end

    if (RATIO == 1) begin : g_equal
        logic [OUT_W-1:0] data_q, data_d;
        logic             tval_q, tval_d;

        assign rrdy_c     = ~tval_q | bus.i_trdy;
        assign bus.o_data = data_q;
        assign bus.o_tval = tval_q;

        always_comb begin
            data_d = data_q;
            tval_d = tval_q;
            if (o_xfer_c) tval_d = 1'b0;
            if (i_xfer_c) begin
                data_d = OUT_W'(bus.i_data);
                tval_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q <= '0;
                tval_q <= 1'b0;
            end else begin
                data_q <= data_d;
                tval_q <= tval_d;
            end
        end
`ifdef CONVERT_W_W_LAST_EN
        logic last_q;
        assign bus.o_last = last_q;
        always_ff @(posedge clk) begin
            if (reset)         last_q <= 1'b0;
            else if (i_xfer_c) last_q <= last_in_c;
        end
`endif
    end else if (OUT_W > IN_W) begin : g_up
        logic [OUT_W-1:0] asm_q, asm_d, out_q, out_d, word_c;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             tval_q, tval_d;
        logic             done_c;

        assign rrdy_c     = ~tval_q | bus.i_trdy;
        assign bus.o_data = out_q;
        assign bus.o_tval = tval_q;

        // Assembly register keeps upper lanes zero so an early flush needs no masking.
        always_comb begin
            word_c = asm_q;
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (cnt_q == CNT_W'(k)) word_c[k*IN_W +: IN_W] = bus.i_data;
            end
        end

        assign done_c = i_xfer_c & ((cnt_q == CNT_W'(RATIO - 1)) | last_in_c);

        always_comb begin
            asm_d  = asm_q;
            out_d  = out_q;
            cnt_d  = cnt_q;
            tval_d = tval_q;
            if (o_xfer_c) tval_d = 1'b0;
            if (done_c) begin
                out_d  = word_c;
                asm_d  = '0;
                cnt_d  = '0;
                tval_d = 1'b1;
            end else if (i_xfer_c) begin
                asm_d = word_c;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                asm_q  <= '0;
                out_q  <= '0;
                cnt_q  <= '0;
                tval_q <= 1'b0;
            end else begin
                asm_q  <= asm_d;
                out_q  <= out_d;
                cnt_q  <= cnt_d;
                tval_q <= tval_d;
            end
        end
`ifdef CONVERT_W_W_LAST_EN
        logic last_q;
        assign bus.o_last = last_q;
        always_ff @(posedge clk) begin
            if (reset)         last_q <= 1'b0;
            else if (done_c)   last_q <= last_in_c;
            else if (o_xfer_c) last_q <= 1'b0;
        end
`endif
    end else begin : g_down
        logic [IN_W-1:0]  buf_q, buf_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             tval_q, tval_d;
        logic [OUT_W-1:0] lane_c;
        logic             at_last_c;

        assign at_last_c  = (cnt_q == CNT_W'(RATIO - 1));
        assign rrdy_c     = ~tval_q | (bus.i_trdy & at_last_c);
        assign bus.o_data = lane_c;
        assign bus.o_tval = tval_q;

        always_comb begin
            lane_c = '0;
            for (int unsigned k = 0; k < RATIO; k++) begin
                if (cnt_q == CNT_W'(k)) lane_c = buf_q[k*OUT_W +: OUT_W];
            end
        end

        // A new word captured on the final lane's handoff overrides the clear.
        always_comb begin
            buf_d  = buf_q;
            cnt_d  = cnt_q;
            tval_d = tval_q;
            if (o_xfer_c) begin
                if (at_last_c) begin
                    tval_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            if (i_xfer_c) begin
                buf_d  = bus.i_data;
                cnt_d  = '0;
                tval_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                buf_q  <= '0;
                cnt_q  <= '0;
                tval_q <= 1'b0;
            end else begin
                buf_q  <= buf_d;
                cnt_q  <= cnt_d;
                tval_q <= tval_d;
            end
        end
`ifdef CONVERT_W_W_LAST_EN
        logic last_q;
        assign bus.o_last = tval_q & last_q & at_last_c;
        always_ff @(posedge clk) begin
            if (reset)         last_q <= 1'b0;
            else if (i_xfer_c) last_q <= last_in_c;
        end
`endif
    end
endmodule

// File: tb/tb_convert_w_w.sv
// Scoreboard bench for convert_w_w: upsize 8->32, downsize 32->8 and equal 8->8 instances.
// CONVERT_W_W_LAST_EN additionally exercises frame-end marking.
module tb_convert_w_w;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    convert_w_w_if #(.IN_W(8),  .OUT_W(32)) up_if ();
    convert_w_w_if #(.IN_W(32), .OUT_W(8))  dn_if ();
    convert_w_w_if #(.IN_W(8),  .OUT_W(8))  eq_if ();

    convert_w_w #(.IN_W(8),  .OUT_W(32)) u_up (.clk(clk), .reset(rst), .bus(up_if.slave));
    convert_w_w #(.IN_W(32), .OUT_W(8))  u_dn (.clk(clk), .reset(rst), .bus(dn_if.slave));
    convert_w_w #(.IN_W(8),  .OUT_W(8))  u_eq (.clk(clk), .reset(rst), .bus(eq_if.slave));

    logic up_ol, dn_ol, eq_ol;
`ifdef CONVERT_W_W_LAST_EN
    assign up_ol = up_if.o_last;
    assign dn_ol = dn_if.o_last;
    assign eq_ol = eq_if.o_last;
`else
    assign up_ol = 1'b0;
    assign dn_ol = 1'b0;
    assign eq_ol = 1'b0;
`endif

    // Expected {last, data}, pushed when stimulus is driven.
    logic [32:0] up_q[$];
    logic [8:0]  dn_q[$];
    logic [8:0]  eq_q[$];
    int          dn_cyc[$];

    always @(negedge clk) begin
        logic [32:0] obs, exp;
        if (!rst && up_if.o_tval && up_if.i_trdy) begin
            obs = {up_ol, up_if.o_data};
            n_tests++;
            if (up_q.size() == 0) begin
                n_fail++;
                $display("FAIL up_out: got %h, required no output", obs);
            end else begin
                exp = up_q.pop_front();
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL up_out: got %h, required %h", obs, exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] obs, exp;
        if (!rst && dn_if.o_tval && dn_if.i_trdy) begin
            obs = {dn_ol, dn_if.o_data};
            dn_cyc.push_back(cyc);
            n_tests++;
            if (dn_q.size() == 0) begin
                n_fail++;
                $display("FAIL dn_out: got %h, required no output", obs);
            end else begin
                exp = dn_q.pop_front();
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL dn_out: got %h, required %h", obs, exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] obs, exp;
        if (!rst && eq_if.o_tval && eq_if.i_trdy) begin
            obs = {eq_ol, eq_if.o_data};
            n_tests++;
            if (eq_q.size() == 0) begin
                n_fail++;
                $display("FAIL eq_out: got %h, required no output", obs);
            end else begin
                exp = eq_q.pop_front();
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL eq_out: got %h, required %h", obs, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic up_beat(input logic [7:0] d, input logic last);
        int  n = 0;
        bit  acc;
        up_if.i_data = d;
        up_if.i_rval = 1'b1;
`ifdef CONVERT_W_W_LAST_EN
        up_if.i_last = last;
`endif
        do begin
            @(negedge clk);
            acc = up_if.o_rrdy;
            tick();
            n++;
        end while (!acc && n < 100);
        up_if.i_rval = 1'b0;
`ifdef CONVERT_W_W_LAST_EN
        up_if.i_last = 1'b0;
`endif
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL up_beat_timeout: got o_rrdy=0 for 100 cycles, required 1");
        end
        if (last) begin end
    endtask

    task automatic dn_beat(input logic [31:0] d, input logic last);
        int  n = 0;
        bit  acc;
        dn_if.i_data = d;
        dn_if.i_rval = 1'b1;
`ifdef CONVERT_W_W_LAST_EN
        dn_if.i_last = last;
`endif
        do begin
            @(negedge clk);
            acc = dn_if.o_rrdy;
            tick();
            n++;
        end while (!acc && n < 100);
        dn_if.i_rval = 1'b0;
`ifdef CONVERT_W_W_LAST_EN
        dn_if.i_last = 1'b0;
`endif
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL dn_beat_timeout: got o_rrdy=0 for 100 cycles, required 1");
        end
        if (last) begin end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((up_q.size() + dn_q.size() + eq_q.size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        n_tests++;
        if ((up_q.size() + dn_q.size() + eq_q.size()) != 0) begin
            n_fail++;
            $display("FAIL drain: got pending up=%0d dn=%0d eq=%0d, required 0 0 0",
                     up_q.size(), dn_q.size(), eq_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests += 3;
        if ({up_if.o_tval, up_if.o_data, up_if.o_rrdy} !== {1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_up: got tval=%b data=%h rrdy=%b, required 0 0 1",
                     up_if.o_tval, up_if.o_data, up_if.o_rrdy);
        end
        if ({dn_if.o_tval, dn_if.o_data, dn_if.o_rrdy} !== {1'b0, 8'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_dn: got tval=%b data=%h rrdy=%b, required 0 0 1",
                     dn_if.o_tval, dn_if.o_data, dn_if.o_rrdy);
        end
        if ({eq_if.o_tval, eq_if.o_data, eq_if.o_rrdy, eq_ol} !== {1'b0, 8'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_eq: got tval=%b data=%h rrdy=%b last=%b, required 0 0 1 0",
                     eq_if.o_tval, eq_if.o_data, eq_if.o_rrdy, eq_ol);
        end
        tick();
    endtask

    task automatic test_upsize();
        logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        up_if.i_trdy = 1'b1;
        up_q.push_back({1'b0, 32'h44332211});
        for (int k = 0; k < 4; k++) begin
            up_if.i_data = b[k];
            up_if.i_rval = 1'b1;
            @(negedge clk);
            n_tests++;
            if (up_if.o_rrdy !== 1'b1 || up_if.o_tval !== 1'b0) begin
                n_fail++;
                $display("FAIL up_beat%0d: got rrdy=%b tval=%b, required 1 0",
                         k, up_if.o_rrdy, up_if.o_tval);
            end
            tick();
        end
        up_if.i_rval = 1'b0;
        @(negedge clk);
        n_tests++;
        if (up_if.o_tval !== 1'b1 || up_if.o_data !== 32'h44332211) begin
            n_fail++;
            $display("FAIL up_latency: got tval=%b data=%h, required 1 44332211",
                     up_if.o_tval, up_if.o_data);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (up_if.o_tval !== 1'b0) begin
            n_fail++;
            $display("FAIL up_tval_drop: got %b, required 0", up_if.o_tval);
        end
        tick();
    endtask

    task automatic test_up_reset();
        up_if.i_trdy = 1'b1;
        up_beat(8'hAA, 1'b0);
        up_beat(8'hBB, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (up_if.o_tval !== 1'b0 || up_if.o_rrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL up_midreset: got tval=%b rrdy=%b, required 0 1",
                     up_if.o_tval, up_if.o_rrdy);
        end
        tick();
        up_q.push_back({1'b0, 32'h04030201});
        for (int k = 1; k <= 4; k++) up_beat(8'(k), 1'b0);
        wait_drain();
    endtask

    task automatic test_up_stall();
        up_if.i_trdy = 1'b0;
        up_q.push_back({1'b0, 32'h0D0C0B0A});
        up_q.push_back({1'b0, 32'h1D1C1B1A});
        for (int k = 0; k < 4; k++) up_beat(8'h0A + 8'(k), 1'b0);
        up_if.i_data = 8'h1A;
        up_if.i_rval = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (up_if.o_rrdy !== 1'b0 || up_if.o_tval !== 1'b1 || up_if.o_data !== 32'h0D0C0B0A) begin
                n_fail++;
                $display("FAIL up_stall%0d: got rrdy=%b tval=%b data=%h, required 0 1 0d0c0b0a",
                         c, up_if.o_rrdy, up_if.o_tval, up_if.o_data);
            end
            tick();
        end
        up_if.i_trdy = 1'b1;
        for (int k = 0; k < 4; k++) up_beat(8'h1A + 8'(k), 1'b0);
        wait_drain();
    endtask

    task automatic test_downsize();
        logic [7:0] exp_b[8] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04, 8'h03, 8'h02, 8'h01};
        dn_if.i_trdy = 1'b1;
        dn_cyc.delete();
        for (int k = 0; k < 8; k++) dn_q.push_back({1'b0, exp_b[k]});
        dn_beat(32'hA1B2C3D4, 1'b0);
        dn_beat(32'h01020304, 1'b0);
        wait_drain();
        n_tests++;
        if (dn_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL dn_count: got %0d beats, required 8", dn_cyc.size());
        end else if (dn_cyc[7] - dn_cyc[0] != 7) begin
            n_fail++;
            $display("FAIL dn_gapless: got span %0d cycles, required 7", dn_cyc[7] - dn_cyc[0]);
        end
    endtask

    task automatic test_equal_stream();
        int         idx = 0;
        bit         hold = 1'b0;
        logic [7:0] prev = 8'h0;
        for (int c = 0; c < 60 && idx < 10; c++) begin
            eq_if.i_trdy = (c % 2 == 0);
            eq_if.i_rval = 1'b1;
            eq_if.i_data = 8'(idx);
            @(negedge clk);
            if (hold) begin
                n_tests++;
                if (eq_if.o_data !== prev) begin
                    n_fail++;
                    $display("FAIL eq_stable: got %h, required %h", eq_if.o_data, prev);
                end
            end
            hold = eq_if.o_tval && !eq_if.i_trdy;
            prev = eq_if.o_data;
            if (eq_if.o_rrdy) begin
                eq_q.push_back({1'b0, 8'(idx)});
                idx++;
            end
            tick();
        end
        eq_if.i_rval = 1'b0;
        eq_if.i_trdy = 1'b1;
        n_tests++;
        if (idx != 10) begin
            n_fail++;
            $display("FAIL eq_accept: got %0d accepted, required 10", idx);
        end
        wait_drain();
    endtask

`ifdef CONVERT_W_W_LAST_EN
    task automatic test_last();
        up_if.i_trdy = 1'b1;
        dn_if.i_trdy = 1'b1;
        up_q.push_back({1'b1, 32'h0000BBAA});
        up_q.push_back({1'b0, 32'h55667788});
        up_beat(8'hAA, 1'b0);
        up_beat(8'hBB, 1'b1);
        up_beat(8'h88, 1'b0);
        up_beat(8'h77, 1'b0);
        up_beat(8'h66, 1'b0);
        up_beat(8'h55, 1'b0);
        dn_q.push_back({1'b0, 8'h44});
        dn_q.push_back({1'b0, 8'h33});
        dn_q.push_back({1'b0, 8'h22});
        dn_q.push_back({1'b1, 8'h11});
        dn_beat(32'h11223344, 1'b1);
        wait_drain();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        up_if.i_data = '0; up_if.i_rval = 1'b0; up_if.i_trdy = 1'b1;
        dn_if.i_data = '0; dn_if.i_rval = 1'b0; dn_if.i_trdy = 1'b1;
        eq_if.i_data = '0; eq_if.i_rval = 1'b0; eq_if.i_trdy = 1'b1;
`ifdef CONVERT_W_W_LAST_EN
        up_if.i_last = 1'b0; dn_if.i_last = 1'b0; eq_if.i_last = 1'b0;
`endif
        test_reset();
        test_upsize();
        test_up_reset();
        test_up_stall();
        test_downsize();
        test_equal_stream();
`ifdef CONVERT_W_W_LAST_EN
        test_last();
`endif
        wait_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
